// File: rtl/mult18_arbiter.sv
// Round-robin arbiter sharing one iterative 18x18 multiplier (start/done
// interface) among NREQ requesters; results return on a valid/ready channel.
module mult18_arbiter #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned W           = 18,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NREQ-1:0]                             req_valid,
  input  logic [NREQ*W-1:0]                           req_a,
  input  logic [NREQ*W-1:0]                           req_b,
  output logic [NREQ-1:0]                             req_ready,
  output logic                                        m_start,
  output logic [W-1:0]                                m_a,
  output logic [W-1:0]                                m_b,
  input  logic [2*W-1:0]                              m_p,
  input  logic                                        m_done,
  output logic                                        rsp_valid,
  input  logic                                        rsp_ready,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [2*W-1:0]                              rsp_p,
  output logic                                        rsp_err,
  output logic                                        busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   last_grant_q;
  logic [CW-1:0]    cnt_q;
  logic [NREQ-1:0]  req_ready_q;
  logic             m_start_q;
  logic [W-1:0]     m_a_q;
  logic [W-1:0]     m_b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [2*W-1:0]   rsp_p_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic             grant_found_d;
  logic [IDW-1:0]   grant_idx_d;
  logic [IDW-1:0]   cand_d;
  logic [W-1:0]     sel_a_d;
  logic [W-1:0]     sel_b_d;

  // Search starts one past the last winner and wraps, giving rotating priority.
  always_comb begin
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    cand_d        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_d = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!grant_found_d && req_valid[cand_d]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = cand_d;
      end
    end
  end

  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx_d == IDW'(i)) begin
        sel_a_d = req_a[i*W +: W];
        sel_b_d = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      cnt_q        <= '0;
      req_ready_q  <= '0;
      m_start_q    <= 1'b0;
      m_a_q        <= '0;
      m_b_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_p_q      <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      req_ready_q <= '0;
      m_start_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            req_ready_q  <= NREQ'(1) << grant_idx_d;
            m_a_q        <= sel_a_d;
            m_b_q        <= sel_b_d;
            rsp_id_q     <= grant_idx_d;
            last_grant_q <= grant_idx_d;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // done is tested first so it wins over a same-cycle timeout
          if (m_done) begin
            rsp_p_q     <= m_p;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (cnt_q == CNT_MAX) begin
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign m_start   = m_start_q;
  assign m_a       = m_a_q;
  assign m_b       = m_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult18_arbiter.sv
// Scoreboard bench for mult18_arbiter with a 4-cycle behavioural multiplier.
module tb_mult18_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 18;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              m_start;
  logic [W-1:0]      m_a, m_b;
  logic [2*W-1:0]    m_p;
  logic              m_done;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [2*W-1:0]    rsp_p;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  mult18_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_p(m_p),
    .m_done(m_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_p(rsp_p), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct { logic [1:0] id; logic [35:0] p; logic err; } rsp_t;
  typedef struct { logic [2:0] oh; logic [17:0] a; logic [17:0] b; } gnt_t;

  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Behavioural multiplier: done pulses 4 cycles after start.
  logic no_done = 1'b0, inject = 1'b0, stale = 1'b0, real_done = 1'b0;
  int cd = 0;
  logic [17:0] pa = '0, pb = '0;
  initial begin
    m_done = 1'b0;
    m_p = '0;
    forever begin
      @(posedge clk); #2;
      m_done = 1'b0;
      real_done = 1'b0;
      if (!rst) stale = 1'b1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_done = 1'b1;
          m_p = pa * pb;
          real_done = !stale;
        end
      end else if (inject) begin
        m_done = 1'b1;
        m_p = 36'h123456789;
        inject = 1'b0;
      end
      if (m_start && !no_done) begin
        cd = 4; pa = m_a; pb = m_b; stale = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents grants or responses.
  logic pend_start = 1'b0, have_hs = 1'b0, prev_stall = 1'b0, prev_rd = 1'b0, prev_valid = 1'b0;
  gnt_t pend;
  int unsigned last_hs = 0, start_cyc = 0;
  logic [1:0] pv_id; logic [35:0] pv_p; logic pv_err;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend_start = 1'b0; have_hs = 1'b0; prev_stall = 1'b0; prev_rd = 1'b0; prev_valid = 1'b0;
      end else begin
        if (pend_start) begin
          chk("m_start", m_start, 1);
          chk("m_a", m_a, pend.a);
          chk("m_b", m_b, pend.b);
          start_cyc = cyc;
          pend_start = 1'b0;
        end else if (m_start) begin
          chk("unexpected_m_start", m_start, 0);
        end
        if (req_ready != '0) begin
          if (gnt_q.size() == 0) chk("unexpected_req_ready", req_ready, 0);
          else begin
            pend = gnt_q.pop_front();
            chk("req_ready", req_ready, pend.oh);
            pend_start = 1'b1;
          end
          if (have_hs) chk("bubble", (cyc - last_hs) >= 2, 1);
        end
        if (prev_rd) chk("done_to_valid", rsp_valid, 1);
        if (prev_stall) begin
          chk("stall_valid", rsp_valid, 1);
          chk("stall_id", rsp_id, pv_id);
          chk("stall_p", rsp_p, pv_p);
          chk("stall_err", rsp_err, pv_err);
        end
        if (rsp_valid && !prev_valid && rsp_q.size() > 0 && rsp_q[0].err)
          chk("timeout_latency", (cyc - start_cyc) <= TO, 1);
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
          else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rsp_id", rsp_id, r.id);
            chk("rsp_p", rsp_p, r.p);
            chk("rsp_err", rsp_err, r.err);
          end
          last_hs = cyc;
          have_hs = 1'b1;
        end
        prev_stall = rsp_valid && !rsp_ready;
        pv_id = rsp_id; pv_p = rsp_p; pv_err = rsp_err;
        prev_rd = m_done && real_done;
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_grant(input int r);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (req_ready[r]) begin req_valid[r] = 1'b0; return; end
    end
    timeout_fail("grant_wait");
  endtask

  task automatic wait_any_grant();
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (req_ready != '0) return;
    end
    timeout_fail("any_grant_wait");
  endtask

  task automatic wait_rsp_valid();
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (rsp_valid) return;
    end
    timeout_fail("rsp_valid_wait");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (rsp_q.size() == 0 && gnt_q.size() == 0 && !busy) return;
    end
    timeout_fail("idle_wait");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_m_start"}, m_start, 0);
    chk({tag, "_m_a"}, m_a, 0);
    chk({tag, "_m_b"}, m_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_p"}, rsp_p, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic set_ops(input int r, input logic [17:0] a, input logic [17:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    step(2);
    @(negedge clk);
    chk_zero("reset");
    step(1);
    rst = 1'b1;
    step(2);

    // All three continuously valid: rotation 0,1,2,0,1,2
    set_ops(0, 18'd7, 18'd9);
    set_ops(1, 18'd100, 18'd200);
    set_ops(2, 18'd1234, 18'd5678);
    for (int n = 0; n < 2; n++) begin
      gnt_q.push_back('{3'b001, 18'd7, 18'd9});
      gnt_q.push_back('{3'b010, 18'd100, 18'd200});
      gnt_q.push_back('{3'b100, 18'd1234, 18'd5678});
      rsp_q.push_back('{2'd0, 36'd63, 1'b0});
      rsp_q.push_back('{2'd1, 36'd20000, 1'b0});
      rsp_q.push_back('{2'd2, 36'd7006652, 1'b0});
    end
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) wait_any_grant();
    req_valid = '0;
    wait_idle();

    // Single request from requester 1
    set_ops(1, 18'd3, 18'd5);
    gnt_q.push_back('{3'b010, 18'd3, 18'd5});
    rsp_q.push_back('{2'd1, 36'd15, 1'b0});
    req_valid[1] = 1'b1;
    wait_grant(1);
    wait_idle();

    // Max operands
    set_ops(0, 18'h3FFFF, 18'h3FFFF);
    gnt_q.push_back('{3'b001, 18'h3FFFF, 18'h3FFFF});
    rsp_q.push_back('{2'd0, 36'hFFFF80001, 1'b0});
    req_valid[0] = 1'b1;
    wait_grant(0);
    wait_idle();

    // Response back-pressure with requester 2 waiting
    rsp_ready = 1'b0;
    set_ops(0, 18'd2, 18'd3);
    gnt_q.push_back('{3'b001, 18'd2, 18'd3});
    rsp_q.push_back('{2'd0, 36'd6, 1'b0});
    req_valid[0] = 1'b1;
    wait_grant(0);
    set_ops(2, 18'd4, 18'd5);
    gnt_q.push_back('{3'b100, 18'd4, 18'd5});
    rsp_q.push_back('{2'd2, 36'd20, 1'b0});
    req_valid[2] = 1'b1;
    wait_rsp_valid();
    for (int n = 0; n < 10; n++) begin
      step(1);
      chk("stall_busy", busy, 1);
      chk("stall_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    wait_grant(2);
    wait_idle();

    // Watchdog abort, then late done in RESP and in IDLE
    no_done = 1'b1;
    rsp_ready = 1'b0;
    set_ops(1, 18'd11, 18'd13);
    gnt_q.push_back('{3'b010, 18'd11, 18'd13});
    rsp_q.push_back('{2'd1, 36'd0, 1'b1});
    req_valid[1] = 1'b1;
    wait_grant(1);
    wait_rsp_valid();
    inject = 1'b1;
    step(3);
    rsp_ready = 1'b1;
    wait_idle();
    inject = 1'b1;
    step(10);
    chk("late_done_no_valid", rsp_valid, 0);
    chk("late_done_not_busy", busy, 0);
    no_done = 1'b0;

    // Reset mid-WAIT; stale done must be ignored, requester 0 wins first
    set_ops(1, 18'd6, 18'd7);
    gnt_q.push_back('{3'b010, 18'd6, 18'd7});
    req_valid[1] = 1'b1;
    wait_grant(1);
    step(3);
    rst = 1'b0;
    step(1);
    chk_zero("midreset");
    rst = 1'b1;
    step(8);
    chk("stale_done_no_valid", rsp_valid, 0);
    set_ops(0, 18'd8, 18'd9);
    set_ops(2, 18'd10, 18'd12);
    gnt_q.push_back('{3'b001, 18'd8, 18'd9});
    gnt_q.push_back('{3'b100, 18'd10, 18'd12});
    rsp_q.push_back('{2'd0, 36'd72, 1'b0});
    rsp_q.push_back('{2'd2, 36'd120, 1'b0});
    req_valid = 3'b101;
    wait_grant(0);
    wait_grant(2);
    wait_idle();

    step(4);
    chk("gnt_queue_drained", gnt_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult18_arbiter.md
Name: mult18_arbiter

Overview:
- Shares one 18x18 iterative multiplier (mult18 start/done interface) among NREQ requesters, e.g. the z0/z1/z2 partial-product lanes of several Karatsuba front-ends.
- Arbitrates round-robin, latches the winner's operands and pulses the multiplier start.
- Waits for done, or aborts on a watchdog timeout.
- Returns the product with the requester ID on a valid/ready response channel.

Parameters:
- NREQ, 3, number of requesters (2..8).
- W, 18, operand width.
- TIMEOUT_CYC, 64, maximum cycles in WAIT before abort (≥2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*W  packed operand A; requester i at [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing.
- req_ready  out  NREQ  one-hot accept pulse.
- m_start  out  1  start pulse to multiplier.
- m_a  out  W  operand A to multiplier.
- m_b  out  W  operand B to multiplier.
- m_p  in  2*W  multiplier product.
- m_done  in  1  multiplier done pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(NREQ) (min 1)  index of the served requester.
- rsp_p  out  2*W  product.
- rsp_err  out  1  response was a timeout abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, and every output goes to 0 (req_ready, m_start, m_a, m_b, rsp_valid, rsp_id, rsp_p, rsp_err, busy). last_grant=NREQ-1, so requester 0 has first priority. Timeout counter=0. Reset during any state aborts that operation immediately; a later m_done is ignored.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit searching from last_grant+1 with wrap-around.
  - req_ready[g]=1 for exactly one cycle.
  - Latch req_a[g] and req_b[g] into m_a/m_b, g into rsp_id; set last_grant=g; go to ISSUE.
  - req_ready is never high outside IDLE, and never for more than one requester.
- ISSUE: m_start=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - m_a/m_b are held stable.
  - On m_done: rsp_p=m_p, rsp_err=0, rsp_valid=1; go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT_CYC-1 without m_done: rsp_p=0, rsp_err=1, rsp_valid=1; go to RESP.
  - If m_done arrives in the same cycle the counter reaches TIMEOUT_CYC-1, m_done wins.
- RESP:
  - rsp_valid, rsp_id, rsp_p and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake, rsp_valid drops at the next edge and the FSM goes to IDLE.
  - No new grant occurs in the handshake cycle. Minimum one bubble cycle: the next req_ready comes at the earliest one cycle after rsp_valid falls.
- m_done outside WAIT is ignored, including a late done after a timeout.
- Requester rules:
  - A requester holds req_valid and its operands until its req_ready pulse.
  - Dropping req_valid before grant is legal; no state is kept for it.
- Latency, with cycle 0 = req_ready pulse:
  - m_start at cycle 1.
  - If m_done is seen at cycle k, rsp_valid rises at cycle k+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…
- Arithmetic: no computation in this block. rsp_p is passed through at full 2*W width; no truncation.

Test Plan (use a behavioural multiplier model with done 4 cycles after start):
- Single request from requester 1, A=3, B=5 → req_ready=3'b010 for one cycle; m_start one cycle later with m_a=3, m_b=5; rsp_valid one cycle after m_done with rsp_id=1, rsp_p=15, rsp_err=0.
- All three requesters continuously valid, rsp_ready=1 → grant order 0,1,2,0,1,2. Each response's rsp_id and product match that requester's operands. At least one idle cycle between rsp handshake and next req_ready.
- Max operands A=B=18'h3FFFF → rsp_p=36'hFFFF80001 (68718952449).
- rsp_ready held low 10 cycles while requester 2 is also valid → rsp fields stable, no req_ready pulses, busy=1. After release, requester 2 is granted.
- Multiplier model never asserts done, TIMEOUT_CYC=64 → rsp_valid with rsp_err=1, rsp_p=0 within 64 cycles of m_start. A late m_done injected in RESP/IDLE causes no response.
- rst driven low for one cycle mid-WAIT → all outputs 0 next edge. After release, requester 0 is granted first. The aborted request's m_done produces no response.
